// File: rtl/audio_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// audio_frame_scheduler_if
// Groups the buffer handshake, consumer request/grant bus, status and
// statistics signals of the audio frame scheduler.
//   master : the scheduler side (drives adv_read_enable, grants, frame_id,
//            timeout_err and the statistics counters)
//   slave  : the input buffer plus DSP lanes side (drives ready/full/valid,
//            lane enable/req/done and clear_err)
// Parameters:
//   NUM_CONSUMERS  number of DSP lanes
//   FRAME_ID_W     width of frame_id
// ---------------------------------------------------------------------------
interface audio_frame_scheduler_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int FRAME_ID_W    = 8
);
    logic                     buffer_ready;
    logic                     buffer_full;
    logic                     sample_valid;
    logic                     adv_read_enable;
    logic [NUM_CONSUMERS-1:0] cons_enable;
    logic [NUM_CONSUMERS-1:0] cons_req;
    logic [NUM_CONSUMERS-1:0] cons_done;
    logic [NUM_CONSUMERS-1:0] cons_grant;
    logic [FRAME_ID_W-1:0]    frame_id;
    logic [NUM_CONSUMERS-1:0] timeout_err;
    logic                     clear_err;
    logic [31:0]              frame_cnt;
    logic [15:0]              overrun_cnt;

    modport master (
        input  buffer_ready, buffer_full, sample_valid,
        input  cons_enable, cons_req, cons_done, clear_err,
        output adv_read_enable, cons_grant, frame_id, timeout_err,
        output frame_cnt, overrun_cnt
    );

    modport slave (
        output buffer_ready, buffer_full, sample_valid,
        output cons_enable, cons_req, cons_done, clear_err,
        input  adv_read_enable, cons_grant, frame_id, timeout_err,
        input  frame_cnt, overrun_cnt
    );
endinterface

// File: rtl/audio_frame_scheduler.sv
// ---------------------------------------------------------------------------
// audio_frame_scheduler
// Shares the multichannel input buffer's parallel read port among
// NUM_CONSUMERS DSP lanes. Each frame, the enabled lanes are served one at a
// time in round-robin order; once all of them are done (or revoked by the
// per-grant watchdog) a single-cycle adv_read_enable pops the frame and
// frame_id advances.
//
// Ports:
//   i_sys_clk    system clock
//   i_sys_rst_n  asynchronous reset, active low
//   bus          audio_frame_scheduler_if.master
//                  in : buffer_ready, buffer_full, sample_valid, cons_enable,
//                       cons_req, cons_done, clear_err
//                  out: adv_read_enable, cons_grant, frame_id, timeout_err,
//                       frame_cnt, overrun_cnt
//
// Optional feature: define AUDIO_FRAME_SCHED_STATS_EN to build the
// frame_cnt / overrun_cnt statistics counters; otherwise both read 0.
// ---------------------------------------------------------------------------
module audio_frame_scheduler #(
    parameter int NUM_CONSUMERS  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FRAME_ID_W     = 8
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    audio_frame_scheduler_if.master bus
);
    localparam int N     = NUM_CONSUMERS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_RELEASE,
        S_SETTLE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [N-1:0]         r_pending;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_lane;
    logic [N-1:0]         r_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_adv;
    logic [FRAME_ID_W-1:0] r_frame_id;
    logic [N-1:0]         r_timeout_err;

    logic [N-1:0]         w_cand;
    logic [PTR_W-1:0]     w_winner;
    logic                 w_lane_done;
    logic                 w_timeout_hit;
    logic                 w_frame_start;
    logic                 w_grant_start;
    logic                 w_grant_end;
    logic                 w_timeout;

    // First candidate at or after ptr, wrapping around the lane count.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N-1:0] cand,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        if (int'(w) == N - 1)
            return '0;
        return w + PTR_W'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PTR_W-1:0] l);
        logic [N-1:0] v;
        v    = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    assign w_cand        = r_pending & bus.cons_req;
    assign w_winner      = rr_pick(w_cand, r_rr_ptr);
    assign w_lane_done   = bus.cons_done[r_lane];
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next_state  = r_state;
        w_frame_start = 1'b0;
        w_grant_start = 1'b0;
        w_grant_end   = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.buffer_ready && (|bus.cons_enable)) begin
                    w_frame_start = 1'b1;
                    w_next_state  = S_ARB;
                end
            end
            S_ARB: begin
                if (r_pending == '0) begin
                    w_next_state = S_RELEASE;
                end else if (|w_cand) begin
                    w_grant_start = 1'b1;
                    w_next_state  = S_GRANT;
                end
            end
            S_GRANT: begin
                // A done arriving on the watchdog's last cycle still counts
                // as a clean release.
                if (w_lane_done) begin
                    w_grant_end  = 1'b1;
                    w_next_state = S_ARB;
                end else if (w_timeout_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_ARB;
                end
            end
            S_RELEASE: w_next_state = S_SETTLE;
            S_SETTLE:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_rr_ptr      <= '0;
            r_lane        <= '0;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_adv         <= 1'b0;
            r_frame_id    <= '0;
            r_timeout_err <= '0;
        end else begin
            r_state <= w_next_state;
            // Registered pulse: high for exactly the RELEASE cycle.
            r_adv   <= (w_next_state == S_RELEASE);

            if (w_frame_start)
                r_pending <= bus.cons_enable;

            if (w_grant_start) begin
                r_grant  <= onehot(w_winner);
                r_lane   <= w_winner;
                r_rr_ptr <= next_ptr(w_winner);
                r_cnt    <= '0;
            end else if (r_state == S_GRANT) begin
                if (w_grant_end || w_timeout) begin
                    r_grant           <= '0;
                    r_pending[r_lane] <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // A timeout in the same cycle as clear_err keeps its bit set.
            r_timeout_err <= (bus.clear_err ? '0 : r_timeout_err) |
                             (w_timeout ? onehot(r_lane) : '0);

            if (r_state == S_RELEASE)
                r_frame_id <= r_frame_id + FRAME_ID_W'(1);
        end
    end

    assign bus.adv_read_enable = r_adv;
    assign bus.cons_grant      = r_grant;
    assign bus.frame_id        = r_frame_id;
    assign bus.timeout_err     = r_timeout_err;

`ifdef AUDIO_FRAME_SCHED_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [15:0] r_overrun_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF)
            return v;
        return v + 16'd1;
    endfunction

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_frame_cnt   <= '0;
            r_overrun_cnt <= '0;
        end else begin
            if (r_state == S_RELEASE)
                r_frame_cnt <= r_frame_cnt + 32'd1;
            if (bus.sample_valid && bus.buffer_full)
                r_overrun_cnt <= sat_inc16(r_overrun_cnt);
        end
    end

    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.overrun_cnt = r_overrun_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats  = bus.sample_valid ^ bus.buffer_full;
    assign bus.frame_cnt   = '0;
    assign bus.overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_audio_frame_scheduler.sv
module tb_audio_frame_scheduler;
    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int FW  = 8;
`ifdef AUDIO_FRAME_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_frame_scheduler_if #(.NUM_CONSUMERS(N), .FRAME_ID_W(FW)) bus ();

    audio_frame_scheduler #(
        .NUM_CONSUMERS (N),
        .TIMEOUT_CYCLES(TMO),
        .FRAME_ID_W    (FW)
    ) dut (
        .i_sys_clk  (clk),
        .i_sys_rst_n(rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a grant, check it is the expected lane, hold 3 cycles, done.
    task automatic serve(input int exp_lane);
        int waited;
        waited = 0;
        while (bus.cons_grant == '0 && waited < 100) begin
            tick();
            waited++;
        end
        chk($sformatf("grant_lane%0d", exp_lane), 32'(bus.cons_grant), 32'(1) << exp_lane);
        if (bus.cons_grant == '0)
            return;
        tick();
        tick();
        bus.cons_done = bus.cons_grant;
        tick();
        bus.cons_done = '0;
        chk($sformatf("grant_drop%0d", exp_lane), 32'(bus.cons_grant), 32'd0);
    endtask

    // Wait for the pop pulse; check width and frame_id advance; stop new frames.
    task automatic wait_adv(input int exp_fid);
        int waited;
        waited = 0;
        while (bus.adv_read_enable !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk("adv_pulse", 32'(bus.adv_read_enable), 32'd1);
        chk("fid_hold", 32'(bus.frame_id), 32'(exp_fid - 1));
        bus.buffer_ready = 1'b0;
        tick();
        chk("adv_width", 32'(bus.adv_read_enable), 32'd0);
        chk("fid_next", 32'(bus.frame_id), 32'(exp_fid));
    endtask

    initial begin
        logic bad;
        int   cnt;
        int   waited;

        bus.buffer_ready = 1'b0;
        bus.buffer_full  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.cons_enable  = '0;
        bus.cons_req     = '0;
        bus.cons_done    = '0;
        bus.clear_err    = 1'b0;
        #2;
        chk("rst_grant", 32'(bus.cons_grant), 32'd0);
        chk("rst_adv", 32'(bus.adv_read_enable), 32'd0);
        chk("rst_fid", 32'(bus.frame_id), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_fcnt", bus.frame_cnt, 32'd0);
        chk("rst_ocnt", 32'(bus.overrun_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // No enabled lanes: the buffer is never popped.
        bus.buffer_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bad = bad | bus.adv_read_enable | (|bus.cons_grant);
        end
        chk("no_enable_idle", 32'(bad), 32'd0);
        bus.buffer_ready = 1'b0;
        tick();

        // Frame 1: all lanes, round-robin from 0.
        bus.cons_enable  = 4'b1111;
        bus.cons_req     = 4'b1111;
        bus.buffer_ready = 1'b1;
        for (int l = 0; l < 4; l++) serve(l);
        wait_adv(1);

        // Frame 2: only lanes 1 and 3 request first; 0 and 2 stall the frame.
        tick();
        bus.cons_req     = 4'b1010;
        bus.buffer_ready = 1'b1;
        serve(1);
        serve(3);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bad = bad | bus.adv_read_enable | (|bus.cons_grant);
        end
        chk("stall_hold", 32'(bad), 32'd0);
        bus.cons_req = 4'b0101;
        serve(0);
        serve(2);
        wait_adv(2);

        // Frame 3: enable=0101, everyone requests; rr pointer is at 3.
        tick();
        bus.cons_enable  = 4'b0101;
        bus.cons_req     = 4'b1111;
        bus.buffer_ready = 1'b1;
        serve(0);
        serve(2);
        wait_adv(3);

        // Frame 4: lane 2 never finishes; other lanes' done is ignored.
        tick();
        bus.cons_enable  = 4'b0100;
        bus.cons_req     = 4'b0100;
        bus.buffer_ready = 1'b1;
        waited = 0;
        while (bus.cons_grant == '0 && waited < 100) begin
            tick();
            waited++;
        end
        chk("tmo_grant", 32'(bus.cons_grant), 32'h4);
        bus.cons_done = 4'b1011;
        cnt = 0;
        while (bus.cons_grant != '0 && cnt < 100) begin
            cnt++;
            tick();
            bus.cons_done = '0;
        end
        chk("tmo_cycles", 32'(cnt), 32'(TMO));
        chk("tmo_err", 32'(bus.timeout_err), 32'h4);
        wait_adv(4);
        chk("tmo_err_sticky", 32'(bus.timeout_err), 32'h4);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("tmo_err_clear", 32'(bus.timeout_err), 32'd0);

        // Reset mid-grant: rr pointer is at 3, so lane 3 is granted first.
        bus.cons_enable  = 4'b1111;
        bus.cons_req     = 4'b1111;
        bus.buffer_ready = 1'b1;
        waited = 0;
        while (bus.cons_grant == '0 && waited < 100) begin
            tick();
            waited++;
        end
        chk("pre_rst_grant", 32'(bus.cons_grant), 32'h8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.cons_grant), 32'd0);
        chk("arst_adv", 32'(bus.adv_read_enable), 32'd0);
        chk("arst_fid", 32'(bus.frame_id), 32'd0);
        chk("arst_err", 32'(bus.timeout_err), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int l = 0; l < 4; l++) serve(l);
        wait_adv(1);

        // Two more single-lane frames for the frame counter.
        for (int f = 2; f <= 3; f++) begin
            tick();
            bus.cons_enable  = 4'b0001;
            bus.cons_req     = 4'b0001;
            bus.buffer_ready = 1'b1;
            serve(0);
            wait_adv(f);
        end
        chk("frame_cnt", bus.frame_cnt, STATS ? 32'd3 : 32'd0);

        // Overruns: five samples while full, one while not full.
        bus.buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_valid = 1'b0;
            tick();
        end
        bus.buffer_full  = 1'b0;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        chk("overrun_cnt", 32'(bus.overrun_cnt), STATS ? 32'd5 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
